// File: rtl/shift_deser8_pkg.sv
// shift_deser8_pkg: shared types and defaults for the serial-to-parallel deserializer
package shift_deser8_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shift_deser8_stage.sv
// deser_shift_stage: assembles serial bits into a word and pulses word_done on the completing strobe
module deser_shift_stage
    import shift_deser8_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             sin_valid,
    input  logic             sin_bit,
    input  logic             msb_first,
    output logic             word_done,
    output logic [WIDTH-1:0] word,
    output logic [CW-1:0]    bit_count
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             dir_eff;
    logic             last_bit;

    // Direction is taken live on the first bit of a word, then frozen in dir_q
    assign dir_eff   = (state_q == IDLE) ? msb_first : dir_q;
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));
    assign word      = dir_eff ? {shreg_q[WIDTH-2:0], sin_bit} : {sin_bit, shreg_q[WIDTH-1:1]};
    assign bit_count = cnt_q;

    // State register; reset drops any partial word at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // Next state: clear beats a strobe, and the strobe that fills the word returns to IDLE
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        word_done = 1'b0;
        if (clear) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
        end else if (sin_valid) begin
            shreg_d   = word;
            dir_d     = dir_eff;
            word_done = last_bit;
            state_d   = last_bit ? IDLE : SHIFT;
            cnt_d     = last_bit ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/shift_deser8.sv
// shift_deser8: serial-to-parallel deserializer with a held output word, valid/ready and sticky overrun
module shift_deser8
    import shift_deser8_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     sin_valid,
    input  logic                     sin_bit,
    input  logic                     msb_first,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    logic             word_done;
    logic [WIDTH-1:0] word;

    deser_shift_stage #(.WIDTH(WIDTH)) u_stage (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .sin_valid (sin_valid),
        .sin_bit   (sin_bit),
        .msb_first (msb_first),
        .word_done (word_done),
        .word      (word),
        .bit_count (bit_count)
    );

    // Holding register: a new word lands if the slot is empty or being drained this edge, else it is lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (word_done && (!out_valid || out_ready)) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else if (word_done) begin
                overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (clear) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_deser8.sv
// tb_shift_deser8: randomized and directed scoreboard bench for shift_deser8
module tb_shift_deser8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         clear = 1'b0;
    logic         sin_valid = 1'b0;
    logic         sin_bit = 1'b0;
    logic         msb_first = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         overrun;
    logic [2:0]   bit_count;

    int checks = 0;
    int passes = 0;

    // Reference model: partial word as a list of bits, a one-entry output slot, sticky flag
    bit     bits[$];
    bit     m_dir;
    bit     m_full;
    bit     m_ovr;
    int     sb[$];

    shift_deser8 #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .sin_valid (sin_valid),
        .sin_bit   (sin_bit),
        .msb_first (msb_first),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int assemble();
        int w = 0;
        for (int i = 0; i < W; i++)
            if (bits[i]) w |= m_dir ? (1 << (W - 1 - i)) : (1 << i);
        return w;
    endfunction

    task automatic model_reset();
        bits.delete();
        m_dir  = 0;
        m_full = 0;
        m_ovr  = 0;
        sb.delete();
    endtask

    // Apply inputs for one edge, then advance the model as that edge dictates
    task automatic cyc(input bit v, input bit b, input bit msb, input bit rdy, input bit clr);
        bit done = 0;
        int w = 0;
        sin_valid = v;
        sin_bit   = b;
        msb_first = msb;
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            bits.delete();
            m_ovr = 0;
        end else if (v) begin
            if (bits.size() == 0) m_dir = msb;
            bits.push_back(b);
            if (bits.size() == W) begin
                w = assemble();
                bits.delete();
                done = 1;
            end
        end
        if (done && (!m_full || rdy)) begin
            m_full = 1;
            sb.push_back(w);
        end else if (done) begin
            m_ovr = 1;
        end else if (m_full && rdy) begin
            m_full = 0;
        end
    endtask

    task automatic send_word(input int w, input bit msb, input bit rdy);
        for (int i = 0; i < W; i++)
            cyc(1, msb ? w[W-1-i] : w[i], msb, rdy, 0);
    endtask

    // Monitor: sample mid-cycle; a visible valid&ready means the front word is consumed on the next edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", out_valid, m_full);
            chk("overrun", overrun, m_ovr);
            chk("bit_count", bit_count, bits.size());
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_word", 1, 0);
                else chk("out_data", out_data, sb.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        #1;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_bit_count", bit_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // LSB-first 1,1,0,0,0,0,0,0 -> 0x03
        send_word(32'h03, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // MSB-first with msb_first toggled mid-word -> 0xC0
        cyc(1, 1, 1, 1, 0);
        cyc(1, 1, 1, 1, 0);
        cyc(1, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Two words with no consumer: second is dropped, overrun set, then drain
        send_word(32'hA5, 0, 0);
        send_word(32'h3C, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Clear: drops partial, clears overrun
        cyc(0, 0, 0, 1, 1);
        // Word held, next word completes on the same edge it is consumed
        send_word(32'h11, 0, 0);
        for (int i = 0; i < W - 1; i++) cyc(1, (32'h5A >> i) & 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Clear after 5 bits then a fresh 0xFF
        send_word(32'h12, 0, 0);
        send_word(32'h34, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        send_word(32'hFF, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Asynchronous reset mid-word with a held word and overrun pending
        send_word(32'h77, 1, 0);
        send_word(32'h66, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_data", out_data, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_overrun", overrun, 0);
        chk("arst_bit_count", bit_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_word(32'h96, 1, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Random traffic
        for (int n = 0; n < 1500; n++)
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 2);

        // Back-to-back with out_ready held high
        cyc(0, 0, 0, 1, 1);
        for (int n = 0; n < 6; n++) send_word($urandom_range(0, 255), $urandom_range(0, 1), 1);
        for (int n = 0; n < 3; n++) cyc(0, 0, 0, 1, 0);
        chk("drain", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
